// File: rtl/kf_pkg.sv
// kf_pkg: shared definitions for the Kalman-filter measurement source.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   Default widths, FSM state type, LFSR tap mask and fixed-point unity constants.
package kf_pkg;

  localparam int KF_WX_DEF = 16;  // Q1.15 state / measurement width
  localparam int KF_WP_DEF = 32;  // Q3.29 covariance width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } kf_state_e;

  // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0] (tap n -> bit n-1).
  localparam logic [15:0] KF_LFSR_TAPS = 16'hB400;

  // Largest representable value in Q1.15, exact 1.0 in Q3.29.
  localparam logic [15:0] KF_Q15_ONE = 16'h7FFF;
  localparam logic [31:0] KF_Q29_ONE = 32'h2000_0000;

endpackage

// File: rtl/kf_lfsr16.sv
// kf_lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11), shifts left on advance.
// Latency: new value visible the cycle after adv_i.
// Backpressure: none; holds its value whenever adv_i is low.
//   Ports: clk, rst_n (async, active-low), adv_i (step once), value_o (current state).
module kf_lfsr16
  import kf_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  assign fb = ^(lfsr_q & KF_LFSR_TAPS);

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) lfsr_d = {lfsr_q[14:0], fb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/kf_meas_source.sv
// kf_meas_source: drives a Kalman filter with noisy measurements of a constant truth value.
// Latency: one INIT cycle after start, then one measurement per filter round trip.
// Backpressure: kf_z/kf_s_valid hold while kf_s_ready is low; one measurement outstanding.
//   Ports: start_i/n_samples_i/truth_i/noise_shift_i/cfg_*_i configure a run; kf_* talk to
//   the filter; busy/done/timeout_err/sample_cnt/last_x_hat/err_acc report status.
//   Define KF_SRC_ERR_ACC_EN to accumulate squared estimate error into err_acc_o.
module kf_meas_source
  import kf_pkg::*;
#(
  parameter int          WX        = KF_WX_DEF,
  parameter int          WP        = KF_WP_DEF,
  parameter int          TIMEOUT   = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [15:0]   n_samples_i,
  input  logic [WX-1:0] truth_i,
  input  logic [3:0]    noise_shift_i,
  input  logic [WX-1:0] cfg_x0_i,
  input  logic [WP-1:0] cfg_p0_i,
  input  logic [WP-1:0] cfg_q_i,
  input  logic [WP-1:0] cfg_r_i,
  output logic          kf_load_init_o,
  output logic [WX-1:0] kf_x0_o,
  output logic [WP-1:0] kf_p0_o,
  output logic [WP-1:0] kf_q_o,
  output logic [WP-1:0] kf_r_o,
  output logic          kf_s_valid_o,
  input  logic          kf_s_ready_i,
  output logic [WX-1:0] kf_z_o,
  input  logic          kf_m_valid_i,
  output logic          kf_m_ready_o,
  input  logic [WX-1:0] kf_x_hat_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          timeout_err_o,
  output logic [15:0]   sample_cnt_o,
  output logic [WX-1:0] last_x_hat_o,
  output logic [47:0]   err_acc_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  kf_state_e     state_q, state_d;
  logic [15:0]   n_q, n_d, cnt_q, cnt_d;
  logic [WX-1:0] truth_q, truth_d, x0_q, x0_d, xhat_q, xhat_d;
  logic [3:0]    shift_q, shift_d;
  logic [WP-1:0] p0_q, p0_d, qn_q, qn_d, rn_q, rn_d;
  logic [TW-1:0] wait_q, wait_d;

  logic               start_ok, s_fire, m_fire, last_sample, wait_expired;
  logic [15:0]        lfsr_val;
  logic signed [15:0] noise;
  logic signed [WX:0] z_sum;
  logic [WX-1:0]      z_sat;

  assign start_ok     = start_i && (state_q == ST_IDLE || state_q == ST_ERR);
  assign s_fire       = (state_q == ST_SEND) && kf_s_ready_i;
  assign m_fire       = (state_q == ST_WAIT) && kf_m_valid_i;
  assign last_sample  = (cnt_q + 16'd1) == n_q;
  assign wait_expired = wait_q == TW'(TIMEOUT - 1);

  // LFSR only steps on an accepted measurement, so kf_z is frozen under backpressure.
  kf_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv_i   (s_fire),
    .value_o (lfsr_val)
  );

  // Measurement = truth + attenuated noise, clamped to the signed WX-bit range.
  assign noise = $signed(lfsr_val) >>> shift_q;
  assign z_sum = $signed({truth_q[WX-1], truth_q}) + (WX+1)'(noise);

  always_comb begin
    z_sat = z_sum[WX-1:0];
    if (z_sum[WX] != z_sum[WX-1])
      z_sat = z_sum[WX] ? {1'b1, {(WX-1){1'b0}}} : {1'b0, {(WX-1){1'b1}}};
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR: if (start_i) state_d = ST_INIT;
      ST_INIT: state_d = (n_q == 16'd0) ? ST_DONE : ST_SEND;
      ST_SEND: if (kf_s_ready_i) state_d = ST_WAIT;
      ST_WAIT: begin
        if (kf_m_valid_i)      state_d = last_sample ? ST_DONE : ST_SEND;
        else if (wait_expired) state_d = ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs (Moore)
  always_comb begin
    kf_load_init_o = 1'b0;
    kf_s_valid_o   = 1'b0;
    kf_m_ready_o   = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    timeout_err_o  = 1'b0;
    case (state_q)
      ST_INIT: begin kf_load_init_o = 1'b1; busy_o = 1'b1; end
      ST_SEND: begin kf_s_valid_o   = 1'b1; busy_o = 1'b1; end
      ST_WAIT: begin kf_m_ready_o   = 1'b1; busy_o = 1'b1; end
      ST_DONE: done_o        = 1'b1;
      ST_ERR:  timeout_err_o = 1'b1;
      default: ;
    endcase
  end

  assign kf_z_o = kf_s_valid_o ? z_sat : '0;

  // Run configuration, sample counter, captured estimate, WAIT timer.
  always_comb begin
    n_d     = n_q;
    truth_d = truth_q;
    shift_d = shift_q;
    x0_d    = x0_q;
    p0_d    = p0_q;
    qn_d    = qn_q;
    rn_d    = rn_q;
    cnt_d   = cnt_q;
    xhat_d  = xhat_q;
    // Zero outside WAIT so every WAIT visit starts counting from 0.
    wait_d  = (state_q == ST_WAIT) ? wait_q + TW'(1) : '0;
    if (start_ok) begin
      n_d     = n_samples_i;
      truth_d = truth_i;
      shift_d = noise_shift_i;
      x0_d    = cfg_x0_i;
      p0_d    = cfg_p0_i;
      qn_d    = cfg_q_i;
      rn_d    = cfg_r_i;
      cnt_d   = '0;
    end
    if (m_fire) begin
      xhat_d = kf_x_hat_i;
      cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q     <= '0;
      truth_q <= '0;
      shift_q <= '0;
      x0_q    <= '0;
      p0_q    <= '0;
      qn_q    <= '0;
      rn_q    <= '0;
      cnt_q   <= '0;
      xhat_q  <= '0;
      wait_q  <= '0;
    end else begin
      n_q     <= n_d;
      truth_q <= truth_d;
      shift_q <= shift_d;
      x0_q    <= x0_d;
      p0_q    <= p0_d;
      qn_q    <= qn_d;
      rn_q    <= rn_d;
      cnt_q   <= cnt_d;
      xhat_q  <= xhat_d;
      wait_q  <= wait_d;
    end
  end

  assign kf_x0_o      = x0_q;
  assign kf_p0_o      = p0_q;
  assign kf_q_o       = qn_q;
  assign kf_r_o       = rn_q;
  assign sample_cnt_o = cnt_q;
  assign last_x_hat_o = xhat_q;

`ifdef KF_SRC_ERR_ACC_EN
  logic [47:0]            acc_q, acc_d;
  logic signed [WX:0]     diff;
  logic signed [2*WX+1:0] diff_x, sq;
  logic [48:0]            acc_sum;

  assign diff    = $signed({kf_x_hat_i[WX-1], kf_x_hat_i}) - $signed({truth_q[WX-1], truth_q});
  assign diff_x  = (2*WX+2)'(diff);
  assign sq      = diff_x * diff_x;
  assign acc_sum = {1'b0, acc_q} + 49'($unsigned(sq));

  always_comb begin
    acc_d = acc_q;
    if (start_ok)    acc_d = '0;
    else if (m_fire) acc_d = acc_sum[48] ? '1 : acc_sum[47:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign err_acc_o = acc_q;
`else
  assign err_acc_o = '0;
`endif

endmodule

// File: tb/tb_kf_meas_source.sv
module tb_kf_meas_source;

  localparam int          WX      = 16;
  localparam int          WP      = 32;
  localparam int          TIMEOUT = 64;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i;
  logic [15:0]   n_samples_i;
  logic [WX-1:0] truth_i;
  logic [3:0]    noise_shift_i;
  logic [WX-1:0] cfg_x0_i;
  logic [WP-1:0] cfg_p0_i, cfg_q_i, cfg_r_i;
  logic          kf_load_init_o;
  logic [WX-1:0] kf_x0_o;
  logic [WP-1:0] kf_p0_o, kf_q_o, kf_r_o;
  logic          kf_s_valid_o, kf_s_ready_i;
  logic [WX-1:0] kf_z_o;
  logic          kf_m_valid_i, kf_m_ready_o;
  logic [WX-1:0] kf_x_hat_i;
  logic          busy_o, done_o, timeout_err_o;
  logic [15:0]   sample_cnt_o;
  logic [WX-1:0] last_x_hat_o;
  logic [47:0]   err_acc_o;

  always #5 clk = ~clk;

  kf_meas_source #(.WX(WX), .WP(WP), .TIMEOUT(TIMEOUT), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .n_samples_i(n_samples_i),
    .truth_i(truth_i), .noise_shift_i(noise_shift_i), .cfg_x0_i(cfg_x0_i),
    .cfg_p0_i(cfg_p0_i), .cfg_q_i(cfg_q_i), .cfg_r_i(cfg_r_i),
    .kf_load_init_o(kf_load_init_o), .kf_x0_o(kf_x0_o), .kf_p0_o(kf_p0_o),
    .kf_q_o(kf_q_o), .kf_r_o(kf_r_o), .kf_s_valid_o(kf_s_valid_o),
    .kf_s_ready_i(kf_s_ready_i), .kf_z_o(kf_z_o), .kf_m_valid_i(kf_m_valid_i),
    .kf_m_ready_o(kf_m_ready_o), .kf_x_hat_i(kf_x_hat_i), .busy_o(busy_o),
    .done_o(done_o), .timeout_err_o(timeout_err_o), .sample_cnt_o(sample_cnt_o),
    .last_x_hat_o(last_x_hat_o), .err_acc_o(err_acc_o)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_lfsr = SEED;   // reference LFSR state
  logic [15:0] m_last = '0;     // reference last_x_hat
  longint      m_acc  = 0;      // reference err_acc
  logic [15:0] last_z = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] exp_z(input logic [15:0] tr, input logic [3:0] sh,
                                        input logic [15:0] l);
    int t, nz, s;
    t  = int'($signed(tr));
    nz = int'($signed(l)) >>> sh;
    s  = t + nz;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic longint acc_add(input longint a, input logic [15:0] x, input logic [15:0] t);
    longint d, r;
    d = longint'($signed(x)) - longint'($signed(t));
    r = a + d * d;
    if (r > 64'sd281474976710655) r = 64'sd281474976710655;
`ifdef KF_SRC_ERR_ACC_EN
    return r;
`else
    return 0;
`endif
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, ".load_init"}, 64'(kf_load_init_o), 64'(0));
    chk({tag, ".x0"},        64'(kf_x0_o),        64'(0));
    chk({tag, ".p0"},        64'(kf_p0_o),        64'(0));
    chk({tag, ".q"},         64'(kf_q_o),         64'(0));
    chk({tag, ".r"},         64'(kf_r_o),         64'(0));
    chk({tag, ".s_valid"},   64'(kf_s_valid_o),   64'(0));
    chk({tag, ".z"},         64'(kf_z_o),         64'(0));
    chk({tag, ".m_ready"},   64'(kf_m_ready_o),   64'(0));
    chk({tag, ".busy"},      64'(busy_o),         64'(0));
    chk({tag, ".done"},      64'(done_o),         64'(0));
    chk({tag, ".tmo"},       64'(timeout_err_o),  64'(0));
    chk({tag, ".cnt"},       64'(sample_cnt_o),   64'(0));
    chk({tag, ".last"},      64'(last_x_hat_o),   64'(0));
    chk({tag, ".acc"},       64'(err_acc_o),      64'(0));
  endtask

  // One run: start pulse, filter model with given latency / ready hold-off, status checks.
  task automatic run_case(input string tag, input int n, input logic [15:0] tr,
                          input logic [3:0] sh, input int lat, input int hold,
                          input bit respond, input bit fixed_x, input logic [15:0] xoff);
    logic [15:0] cx0, xv;
    logic [31:0] cp0, cq, cr;
    int sent, got, hold_left, resp_timer, wcyc, cyc;
    bit fin_done, fin_err;
    sent = 0; got = 0; hold_left = hold; resp_timer = 0; wcyc = 0; cyc = 0;
    fin_done = 0; fin_err = 0;
    cx0 = 16'($urandom); cp0 = $urandom; cq = $urandom; cr = $urandom;
    start_i = 1'b1; n_samples_i = 16'(n); truth_i = tr; noise_shift_i = sh;
    cfg_x0_i = cx0; cfg_p0_i = cp0; cfg_q_i = cq; cfg_r_i = cr;
    m_acc = 0;
    @(negedge clk);
    // Scramble inputs: the run must use only what was captured at start.
    start_i = 1'b0; n_samples_i = 16'($urandom); truth_i = 16'($urandom);
    noise_shift_i = 4'($urandom); cfg_x0_i = 16'($urandom);
    cfg_p0_i = $urandom; cfg_q_i = $urandom; cfg_r_i = $urandom;
    chk({tag, ".init_pulse"}, 64'(kf_load_init_o), 64'(1));
    chk({tag, ".init_x0"},    64'(kf_x0_o),        64'(cx0));
    chk({tag, ".init_p0"},    64'(kf_p0_o),        64'(cp0));
    chk({tag, ".init_q"},     64'(kf_q_o),         64'(cq));
    chk({tag, ".init_r"},     64'(kf_r_o),         64'(cr));
    chk({tag, ".init_busy"},  64'(busy_o),         64'(1));
    while (!fin_done && !fin_err && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0; kf_s_ready_i = 1'b0; kf_m_valid_i = 1'b0;
      if (done_o) fin_done = 1;
      else if (timeout_err_o) fin_err = 1;
      else begin
        chk({tag, ".busy"}, 64'(busy_o), 64'(1));
        if (kf_s_valid_o) begin
          chk({tag, ".one_outstanding"}, 64'(kf_m_ready_o), 64'(0));
          chk({tag, ".z"}, 64'(kf_z_o), 64'(exp_z(tr, sh, m_lfsr)));
          last_z  = kf_z_o;
          start_i = 1'($urandom);  // must be ignored mid-run
          if (hold_left > 0) hold_left--;
          else begin
            kf_s_ready_i = 1'b1;
            m_lfsr = lfsr_next(m_lfsr);
            sent++; resp_timer = lat; hold_left = hold; wcyc = 0;
          end
        end
        if (kf_m_ready_o) begin
          wcyc++;
          if (respond && resp_timer <= 0) begin
            xv = fixed_x ? tr + xoff : 16'($urandom);
            kf_m_valid_i = 1'b1; kf_x_hat_i = xv;
            got++; m_last = xv; m_acc = acc_add(m_acc, xv, tr);
          end else resp_timer--;
        end else begin
          // Estimates offered outside WAIT must be ignored.
          kf_m_valid_i = 1'($urandom); kf_x_hat_i = 16'($urandom);
        end
      end
    end
    start_i = 1'b0; kf_s_ready_i = 1'b0; kf_m_valid_i = 1'b0;
    chk({tag, ".finished"}, 64'(fin_done | fin_err), 64'(1));
    chk({tag, ".outcome"},  64'({fin_done, fin_err}), respond ? 64'(2) : 64'(1));
    chk({tag, ".sent"},     64'(sent), respond ? 64'(n) : 64'(n > 0 ? 1 : 0));
    chk({tag, ".cnt"},      64'(sample_cnt_o), 64'(got));
    chk({tag, ".last"},     64'(last_x_hat_o), 64'(m_last));
    chk({tag, ".acc"},      64'(err_acc_o), 64'(m_acc));
    chk({tag, ".q_hold"},   64'(kf_q_o), 64'(cq));
    chk({tag, ".r_hold"},   64'(kf_r_o), 64'(cr));
    chk({tag, ".end_busy"}, 64'(busy_o), 64'(0));
    if (n == 0) chk({tag, ".done_cycle"}, 64'(cyc), 64'(1));
    if (fin_err) chk({tag, ".wait_cycles"}, 64'(wcyc), 64'(TIMEOUT));
    @(negedge clk);
    if (fin_done) begin
      chk({tag, ".done_1cyc"}, 64'(done_o), 64'(0));
      chk({tag, ".idle_busy"}, 64'(busy_o), 64'(0));
    end
    if (fin_err) begin
      chk({tag, ".err_hold"},  64'(timeout_err_o), 64'(1));
      chk({tag, ".err_busy"},  64'(busy_o), 64'(0));
    end
  endtask

  initial begin
    int guard;
    start_i = 1'b0; n_samples_i = '0; truth_i = '0; noise_shift_i = '0;
    cfg_x0_i = '0; cfg_p0_i = '0; cfg_q_i = '0; cfg_r_i = '0;
    kf_s_ready_i = 1'b0; kf_m_valid_i = 1'b0; kf_x_hat_i = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Positive saturation: second LFSR value from the seed is large and positive.
    run_case("sat_pos", 2, 16'h7FF0, 4'd0, 3, 0, 1, 0, 16'd0);
    chk("sat_pos.z2", 64'(last_z), 64'(16'h7FFF));

    run_case("basic", 4, 16'h1000, 4'd15, 10, 0, 1, 1, 16'd3);
    run_case("zero", 0, 16'h0123, 4'd3, 2, 0, 1, 0, 16'd0);
    run_case("hold", 3, 16'($urandom), 4'($urandom), 4, 5, 1, 0, 16'd0);
    run_case("sat_neg", 3, 16'h8010, 4'd0, 1, 1, 1, 0, 16'd0);
    for (int i = 0; i < 6; i++)
      run_case("rand", $urandom_range(1, 5), 16'($urandom), 4'($urandom),
               $urandom_range(0, 20), $urandom_range(0, 3), 1, 0, 16'd0);

    run_case("timeout", 2, 16'h0400, 4'd8, 0, 0, 0, 0, 16'd0);
    run_case("restart", 1, 16'hF000, 4'd4, 5, 0, 1, 0, 16'd0);

    run_case("acc", 2, 16'h2345, 4'd6, 2, 1, 1, 1, 16'd3);
`ifdef KF_SRC_ERR_ACC_EN
    chk("acc.eq18", 64'(err_acc_o), 64'(18));
`else
    chk("acc.off", 64'(err_acc_o), 64'(0));
`endif

    // Reset while waiting for an estimate.
    start_i = 1'b1; n_samples_i = 16'd3; truth_i = 16'h0100; noise_shift_i = 4'd5;
    cfg_q_i = 32'h1234_5678; cfg_r_i = 32'h0BAD_F00D;
    @(negedge clk);
    start_i = 1'b0;
    guard = 0;
    while (!kf_m_ready_o && guard < 20) begin
      if (kf_s_valid_o) begin
        kf_s_ready_i = 1'b1;
        m_lfsr = lfsr_next(m_lfsr);
      end
      @(negedge clk);
      kf_s_ready_i = 1'b0;
      guard++;
    end
    chk("rst_mid.in_wait", 64'(kf_m_ready_o), 64'(1));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_mid");
    m_lfsr = SEED; m_last = '0; m_acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("rst_after");

    run_case("post_rst", 2, 16'h0200, 4'd2, 3, 0, 1, 0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
